// File: rtl/k_aud_cmprs_pkg.sv
// Shared types and width helpers for the audio compressor datapath blocks.
package k_aud_cmprs_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } frame_state_t;

  function automatic int k_sq_width(input int in_width);
    return 2 * in_width;
  endfunction

  // A one-entry frame still needs a 1-bit counter to keep the compare well-formed.
  function automatic int k_cnt_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/k_cplx_mag_sq.sv
// Three-stage complex magnitude-squared pipe (register, square, sum) with
// valid/last sideband; every stage freezes while hold is high.
module k_cplx_mag_sq
  import k_aud_cmprs_pkg::*;
#(
  parameter  int IN_WIDTH = 16,
  localparam int SQ_WIDTH = k_sq_width(IN_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  in_valid,
  input  logic [2*IN_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SQ_WIDTH-1:0]   out_sum
);

  logic [IN_WIDTH-1:0] re0, im0, mag_re, mag_im;
  logic [SQ_WIDTH-2:0] mag_re_ext, mag_im_ext, sq_re, sq_im;
  logic                v0, l0, v1, l1;

  // Squaring the magnitude keeps (-2^(IN_WIDTH-1))^2 exact in 2*IN_WIDTH-1 bits.
  always_comb begin
    mag_re     = re0[IN_WIDTH-1] ? -re0 : re0;
    mag_im     = im0[IN_WIDTH-1] ? -im0 : im0;
    mag_re_ext = {{(SQ_WIDTH-1-IN_WIDTH){1'b0}}, mag_re};
    mag_im_ext = {{(SQ_WIDTH-1-IN_WIDTH){1'b0}}, mag_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0  <= 1'b0;
      l0  <= 1'b0;
      re0 <= '0;
      im0 <= '0;
    end else if (!hold) begin
      v0 <= in_valid;
      if (in_valid) begin
        re0 <= in_data[2*IN_WIDTH-1:IN_WIDTH];
        im0 <= in_data[IN_WIDTH-1:0];
        l0  <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      l1    <= 1'b0;
      sq_re <= '0;
      sq_im <= '0;
    end else if (!hold) begin
      v1    <= v0;
      l1    <= l0;
      sq_re <= mag_re_ext * mag_re_ext;
      sq_im <= mag_im_ext * mag_im_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sum   <= '0;
    end else if (!hold) begin
      out_valid <= v1;
      out_last  <= l1;
      out_sum   <= {1'b0, sq_re} + {1'b0, sq_im};
    end
  end

endmodule

// File: rtl/k_frame_energy_acc.sv
// Frame energy accumulator: sums |x|^2 per frame behind an AXI-Stream pipe.
// Define K_ENERGY_SAT_EN to saturate on overflow instead of wrapping.
module k_frame_energy_acc
  import k_aud_cmprs_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int FRAME_LEN = 256,
  parameter int ACC_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [2*IN_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ACC_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tuser
);

  localparam int SQ_WIDTH  = k_sq_width(IN_WIDTH);
  localparam int CNT_WIDTH = k_cnt_width(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_LEN - 1);

  frame_state_t          state, state_next;
  logic                  stall, s2_valid, s2_last, s3_fire, frame_end, carry, ovf_now, ovf;
  logic [SQ_WIDTH-1:0]   s2_sum;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ACC_WIDTH-1:0]  acc, acc_next;
  logic [ACC_WIDTH:0]    acc_sum;

  k_cplx_mag_sq #(.IN_WIDTH(IN_WIDTH)) u_mag_sq (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .in_valid  (s_axis_tvalid),
    .in_data   (s_axis_tdata),
    .in_last   (s_axis_tlast),
    .out_valid (s2_valid),
    .out_last  (s2_last),
    .out_sum   (s2_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if ((s3_fire && frame_end && !m_axis_tready) ||
                 (m_axis_tvalid && !m_axis_tready)) state_next = HOLD;
      HOLD:  if (m_axis_tready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // HOLD always implies a pending word, so this equals tvalid && !tready.
  always_comb begin
    stall         = (state == HOLD || m_axis_tvalid) && !m_axis_tready;
    s_axis_tready = !stall;
  end

  always_comb begin
    s3_fire   = s2_valid && !stall;
    frame_end = (cnt == CNT_LAST) || s2_last;
    acc_sum   = {1'b0, acc} + {{(ACC_WIDTH+1-SQ_WIDTH){1'b0}}, s2_sum};
    carry     = acc_sum[ACC_WIDTH];
    ovf_now   = ovf || carry;
`ifdef K_ENERGY_SAT_EN
    acc_next  = ovf_now ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
    acc_next  = acc_sum[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (s3_fire) begin
      if (frame_end) begin
        cnt <= '0;
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
        acc <= acc_next;
        ovf <= ovf_now;
      end
    end
  end

  // A frame end on the handshake edge reloads the word without dropping tvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
    end else if (s3_fire && frame_end) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= acc_next;
      m_axis_tuser  <= ovf_now;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_k_frame_energy_acc.sv
// Self-checking bench for k_frame_energy_acc: directed table, multi-cycle corner
// cases and randomized traffic against a frame-level reference model.
module tb_k_frame_energy_acc;

  localparam int IN_WIDTH  = 16;
  localparam int FRAME_LEN = 4;
`ifdef K_ENERGY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid, s_axis_tlast, m_tready, f1_m_tready;
  logic [31:0] s_axis_tdata;
  logic        s_tready48, m_tvalid48, m_tuser48;
  logic [47:0] m_tdata48;
  logic        s_tready33, m_tvalid33, m_tuser33;
  logic [32:0] m_tdata33;
  logic        f1_s_tready, f1_m_tvalid, f1_m_tuser;
  logic [47:0] f1_m_tdata;

  always #5 clk = ~clk;

  k_frame_energy_acc #(.IN_WIDTH(IN_WIDTH), .FRAME_LEN(FRAME_LEN), .ACC_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready48),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .m_axis_tvalid(m_tvalid48),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata48), .m_axis_tuser(m_tuser48));

  k_frame_energy_acc #(.IN_WIDTH(IN_WIDTH), .FRAME_LEN(FRAME_LEN), .ACC_WIDTH(33)) dut33 (
    .clk(clk), .rst(rst), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_tready33),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .m_axis_tvalid(m_tvalid33),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata33), .m_axis_tuser(m_tuser33));

  k_frame_energy_acc #(.IN_WIDTH(IN_WIDTH), .FRAME_LEN(1), .ACC_WIDTH(48)) dut_f1 (
    .clk(clk), .rst(rst), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(f1_s_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .m_axis_tvalid(f1_m_tvalid),
    .m_axis_tready(f1_m_tready), .m_axis_tdata(f1_m_tdata), .m_axis_tuser(f1_m_tuser));

  int n_pass  = 0;
  int n_total = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: exact frame totals, reduced to a given width at output time.
  function automatic longint energy(input int re, input int im);
    return longint'(re) * re + longint'(im) * im;
  endfunction

  function automatic longint expect_word(input longint total, input int w);
    longint lim = longint'(1) << w;
    if (total >= lim) return SAT ? lim - 1 : total % lim;
    return total;
  endfunction

  function automatic bit expect_ovf(input longint total, input int w);
    return total >= (longint'(1) << w);
  endfunction

  typedef struct {
    longint d48;
    longint d33;
    bit     u33;
  } obs_t;

  longint cur_total;
  int     cur_count;
  longint exp_q[$];
  longint f1_q[$];
  obs_t   obs_q[$];
  bit     hold_prev;
  longint prev_data;
  bit     prev_user;
  int     mon_re, mon_im;
  longint mon_tot;

  // Everything is observed at negedge: values seen here are what the next posedge uses.
  always @(negedge clk) begin
    if (rst) begin
      cur_total = 0;
      cur_count = 0;
      exp_q.delete();
      f1_q.delete();
      hold_prev = 1'b0;
      checkOutput("rst_m_tvalid48", m_tvalid48, 0);
      checkOutput("rst_m_tdata48", m_tdata48, 0);
      checkOutput("rst_m_tuser48", m_tuser48, 0);
      checkOutput("rst_m_tvalid33", m_tvalid33, 0);
      checkOutput("rst_m_tdata33", m_tdata33, 0);
      checkOutput("rst_m_tuser33", m_tuser33, 0);
      checkOutput("rst_f1_m_tvalid", f1_m_tvalid, 0);
    end else begin
      if (m_tvalid48 && m_tready) begin
        checkOutput("lockstep_m_tvalid33", m_tvalid33, 1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame_output", 1, 0);
        end else begin
          mon_tot = exp_q.pop_front();
          checkOutput("model_tdata48", m_tdata48, expect_word(mon_tot, 48));
          checkOutput("model_tuser48", m_tuser48, expect_ovf(mon_tot, 48));
          checkOutput("model_tdata33", m_tdata33, expect_word(mon_tot, 33));
          checkOutput("model_tuser33", m_tuser33, expect_ovf(mon_tot, 33));
          obs_q.push_back('{d48: m_tdata48, d33: m_tdata33, u33: m_tuser33});
        end
      end
      if (hold_prev && m_tvalid48) begin
        checkOutput("stall_tdata_stable", m_tdata48, prev_data);
        checkOutput("stall_tuser_stable", m_tuser48, prev_user);
      end
      hold_prev = m_tvalid48 && !m_tready;
      prev_data = m_tdata48;
      prev_user = m_tuser48;

      if (s_axis_tvalid && s_tready48) begin
        mon_re = int'($signed(s_axis_tdata[31:16]));
        mon_im = int'($signed(s_axis_tdata[15:0]));
        cur_total += energy(mon_re, mon_im);
        cur_count++;
        if (s_axis_tlast || cur_count == FRAME_LEN) begin
          exp_q.push_back(cur_total);
          cur_total = 0;
          cur_count = 0;
        end
      end

      if (f1_m_tvalid && f1_m_tready) begin
        if (f1_q.size() == 0) begin
          checkOutput("f1_unexpected_output", 1, 0);
        end else begin
          checkOutput("f1_tdata", f1_m_tdata, f1_q.pop_front());
          checkOutput("f1_tuser", f1_m_tuser, 0);
        end
      end
      if (s_axis_tvalid && f1_s_tready)
        f1_q.push_back(energy(int'($signed(s_axis_tdata[31:16])), int'($signed(s_axis_tdata[15:0]))));
    end
  end

  // Presents one sample and returns #1 after the edge on which it was accepted.
  task automatic applyStimulus(input int re, input int im, input bit last);
    bit done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {16'(re), 16'(im)};
    s_axis_tlast  = last;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = s_tready48;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("input_accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rand_comp();
    int r = int'($urandom_range(0, 7));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  typedef struct {
    int     re;
    int     im;
    bit     last;
    bit     closes;
    longint exp48;
    longint exp33;
    bit     user33;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input int re, input int im, input bit last, input bit closes,
                        input longint e48, input longint e33, input bit u33);
    vecs.push_back('{re: re, im: im, last: last, closes: closes, exp48: e48, exp33: e33, user33: u33});
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  bit     stall_seen;
  bit     rand_done;
  int     k;

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    m_tready      = 1'b1;
    f1_m_tready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Directed table: each closing sample carries the frame's hand-computed result.
    for (int i = 0; i < 3; i++) addVec(3, 4, 0, 0, 0, 0, 0);
    addVec(3, 4, 0, 1, 100, 100, 0);
    for (int i = 0; i < 3; i++) addVec(-32768, -32768, 0, 0, 0, 0, 0);
    addVec(-32768, -32768, 0, 1, 64'h2_0000_0000, SAT ? 64'h1_FFFF_FFFF : 64'h0, 1);
    addVec(1, 0, 0, 0, 0, 0, 0);
    addVec(0, 2, 1, 1, 5, 5, 0);
    for (int i = 0; i < 3; i++) addVec(1, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 1, 8, 8, 0);
    for (int i = 0; i < 3; i++) addVec(0, 1, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 1, 4, 4, 0);
    addVec(-1, 0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) addVec(2, -3, 0, 0, 0, 0, 0);
    addVec(2, -3, 0, 1, 52, 52, 0);

    obs_q.delete();
    foreach (vecs[i]) applyStimulus(vecs[i].re, vecs[i].im, vecs[i].last);
    idle(8);
    k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].closes) begin
        if (k < obs_q.size()) begin
          checkOutput($sformatf("table_tdata48_%0d", i), obs_q[k].d48, vecs[i].exp48);
          checkOutput($sformatf("table_tdata33_%0d", i), obs_q[k].d33, vecs[i].exp33);
          checkOutput($sformatf("table_tuser33_%0d", i), obs_q[k].u33, vecs[i].user33);
        end
        k++;
      end
    end
    checkOutput("table_frame_count", obs_q.size(), k);

    // Latency: last sample accepted at edge E, tvalid rises after E+3.
    for (int i = 0; i < 3; i++) applyStimulus(3, 4, 0);
    applyStimulus(3, 4, 0);
    @(posedge clk); #1;
    checkOutput("latency_e1_tvalid", m_tvalid48, 0);
    @(posedge clk); #1;
    checkOutput("latency_e2_tvalid", m_tvalid48, 0);
    @(posedge clk); #1;
    checkOutput("latency_e3_tvalid", m_tvalid48, 1);
    checkOutput("latency_e3_tdata", m_tdata48, 100);
    idle(4);

    // Output backpressure for 10 cycles while the source keeps streaming.
    stall_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(rand_comp(), rand_comp(), 1'b0);
      end
      begin
        for (int c = 0; c < 100 && !stall_seen; c++) begin
          @(posedge clk); #1;
          stall_seen = m_tvalid48;
        end
        if (!stall_seen) checkOutput("stall_first_frame_timeout", 0, 1);
        m_tready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          checkOutput("stall_s_tready", s_tready48, 0);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
      end
    join
    idle(10);
    checkOutput("stall_frames_drained", exp_q.size(), 0);

    // Reset mid-frame: the two accepted samples must leave no residue.
    applyStimulus(5, 5, 0);
    applyStimulus(5, 5, 0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    obs_q.delete();
    for (int i = 0; i < 4; i++) applyStimulus(2, 0, 0);
    idle(8);
    checkOutput("reset_frame_count", obs_q.size(), 1);
    if (obs_q.size() > 0) checkOutput("reset_frame_tdata", obs_q[0].d48, 16);

    // Randomized traffic with bubbles, early tlast and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
          applyStimulus(rand_comp(), rand_comp(), $urandom_range(0, 7) == 0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    idle(12);
    checkOutput("final_pending_frames", exp_q.size(), 0);
    checkOutput("final_f1_pending", f1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/k_frame_energy_acc.md
Name: k_frame_energy_acc

Overview:
- Pipelined complex-energy accumulator on the audio compressor datapath. Takes one complex sample per cycle and computes |x|^2 = re^2 + im^2.
- Sums |x|^2 over a frame of FRAME_LEN samples, or fewer if s_axis_tlast arrives first, and emits one frame energy word per frame.
- Full AXI-Stream handshakes on both sides: throughput 1 sample/cycle, with output backpressure.

Parameters:
- IN_WIDTH, 16, width of each signed component (re, im).
- FRAME_LEN, 256, samples per frame; must be >= 1.
- ACC_WIDTH, 48, frame energy width; must be >= 2*IN_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_tvalid  in  1  input sample valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  2*IN_WIDTH  signed re in [2*IN_WIDTH-1:IN_WIDTH], signed im in [IN_WIDTH-1:0]
- s_axis_tlast  in  1  closes the current frame early with this sample
- m_axis_tvalid  out  1  frame energy valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  ACC_WIDTH  unsigned frame energy
- m_axis_tuser  out  1  accumulator overflow occurred in this frame

Behaviour:
- Reset: rst asserted clears all pipeline valids, sample counter, accumulator and overflow flag at once. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0. Mid-frame reset discards the partial frame and any pending output.
- Stall: stall = m_axis_tvalid && !m_axis_tready. s_axis_tready = !stall, combinational. While stalled, every pipeline stage, the counter and the accumulator hold.
- Pipeline, each stage with its own valid and last bit:
  - S0: register re/im on handshake.
  - S1: signed squares, each 2*IN_WIDTH-1 bits unsigned. (-2^(IN_WIDTH-1))^2 must be exact.
  - S2: sum, 2*IN_WIDTH bits unsigned.
  - S3: accumulate.
- Sample counter: counts S2-valid samples, 0..FRAME_LEN-1. Frame end = counter==FRAME_LEN-1 OR S2 last bit set. At frame end the counter returns to 0.
- Accumulate (S2 valid, not frame end): acc <= acc + sum at ACC_WIDTH+1 bits. A carry out sets the sticky overflow flag.
- Frame end edge:
  - m_axis_tdata <= acc + sum, with overflow handling per the optional feature.
  - m_axis_tuser <= overflow flag OR carry from this add.
  - m_axis_tvalid <= 1.
  - acc and flag clear the same cycle.
- Latency: last sample of a frame accepted at edge E gives m_axis_tvalid high after edge E+3.
- Output register: m_axis_tvalid drops on the handshake edge unless a new frame end lands on that same edge, in which case the new word loads and tvalid stays 1. tdata/tuser are stable while tvalid && !tready.
- Boundaries:
  - FRAME_LEN=1: every sample is a frame.
  - tlast on the first sample of a frame gives a 1-sample frame.
  - tlast coinciding with counter==FRAME_LEN-1 closes one frame, not two.
  - Back-to-back frames are gapless.
  - s_axis_tvalid low simply bubbles the pipeline; the partial frame persists indefinitely.
- Control is a two-state frame FSM:
  - ACCUM: frame in progress.
  - HOLD: output pending and stalled.
  - ACCUM->HOLD on frame end with m_axis_tready=0. HOLD->ACCUM on output handshake.

Optional Feature:
- Macro K_ENERGY_SAT_EN.
- Defined: on overflow, m_axis_tdata clamps to all ones (2^ACC_WIDTH-1), and the accumulator stays saturated for the rest of the frame.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH.
- m_axis_tuser reports overflow in both builds.

Decomposition:
- Package k_aud_cmprs_pkg holds:
  - frame FSM state enum (ACCUM, HOLD);
  - function k_sq_width(IN_WIDTH)=2*IN_WIDTH;
  - clog2-based counter width localparam helper.
- Sub-module k_cplx_mag_sq: stages S0-S2 with valid/last sideband and hold enable. Reusable by later compressor blocks.

Test Plan:
- IN_WIDTH=16, FRAME_LEN=4, four samples (3,4), tready=1 -> one output 100, tuser=0, valid 3 cycles after the 4th handshake.
- Four samples (-32768,-32768), ACC_WIDTH=48 -> output 0x2_0000_0000, tuser=0. Squares exact.
- ACC_WIDTH=33, same four samples:
  - with K_ENERGY_SAT_EN -> 0x1_FFFF_FFFF, tuser=1;
  - without -> 0x0_0000_0000, tuser=1.
- FRAME_LEN=4, tlast on 2nd sample of (1,0),(0,2), then 4 samples (1,1) -> outputs 5 then 8, with the counter realigned.
- Continuous input, m_axis_tready held 0 for 10 cycles after the first frame -> s_axis_tready=0 during the stall, no sample lost. The second frame value is correct after release, and tdata is stable while stalled.
- rst pulsed after 2 samples of a frame, then 4 samples (2,0) -> single output 16, no residue from the aborted frame. All outputs 0 during rst.
